// File: rtl/nes_joypad_responder.sv
// NES joypad / Four Score responder. Latches the parallel button state while
// the strobe is high and advances a per-port serial stream on each completed
// read pulse (rising edge of the active-low enable).
module nes_joypad_responder #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       OUT0,
  input  logic       n_IN0,
  input  logic       n_IN1,
  input  logic       FS_EN,
  input  logic [7:0] PAD1,
  input  logic [7:0] PAD2,
  input  logic [7:0] PAD3,
  input  logic [7:0] PAD4,
  output logic       SER0,
  output logic       SER1
);

  localparam int unsigned SrWidth = 24;
  localparam logic [4:0]  CntMax  = 5'd24;

  logic [SYNC_STAGES-1:0] strobe_sync_q;
  logic [SYNC_STAGES-1:0] in0_sync_q;
  logic [SYNC_STAGES-1:0] in1_sync_q;
  logic                   in0_prev_q;
  logic                   in1_prev_q;

  logic [1:0][SrWidth-1:0] sr_q, sr_d;
  logic [1:0][SrWidth-1:0] load_val;
  logic [1:0][4:0]         cnt_q, cnt_d;
  logic [1:0]              ser_q;
  logic [1:0]              shift;
  logic                    load;

  // Synchronizers plus edge-detect history; enables idle high so reset release
  // never looks like a completed read pulse.
  always_ff @(posedge CLK) begin
    if (RES) begin
      strobe_sync_q <= '0;
      in0_sync_q    <= '1;
      in1_sync_q    <= '1;
      in0_prev_q    <= 1'b1;
      in1_prev_q    <= 1'b1;
    end else begin
      strobe_sync_q <= {strobe_sync_q[SYNC_STAGES-2:0], OUT0};
      in0_sync_q    <= {in0_sync_q[SYNC_STAGES-2:0], n_IN0};
      in1_sync_q    <= {in1_sync_q[SYNC_STAGES-2:0], n_IN1};
      in0_prev_q    <= in0_sync_q[SYNC_STAGES-1];
      in1_prev_q    <= in1_sync_q[SYNC_STAGES-1];
    end
  end

  // Load and shift qualifiers; a read edge during load is dropped.
  always_comb begin
    load     = strobe_sync_q[SYNC_STAGES-1];
    shift[0] = in0_sync_q[SYNC_STAGES-1] & ~in0_prev_q & ~load;
    shift[1] = in1_sync_q[SYNC_STAGES-1] & ~in1_prev_q & ~load;
    // Four Score appends an adapter signature after the two pad bytes.
    load_val[0] = FS_EN ? {8'b0000_1000, PAD3, PAD1} : {16'hFFFF, PAD1};
    load_val[1] = FS_EN ? {8'b0000_0100, PAD4, PAD2} : {16'hFFFF, PAD2};
  end

  // Next-state of both shift registers and read counters.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    for (int p = 0; p < 2; p++) begin
      if (load) begin
        sr_d[p]  = load_val[p];
        cnt_d[p] = 5'd0;
      end else if (shift[p]) begin
        sr_d[p] = {1'b1, sr_q[p][SrWidth-1:1]};
        if (cnt_q[p] != CntMax) begin
          cnt_d[p] = cnt_q[p] + 5'd1;
        end
      end
    end
  end

  // Stream state and registered serial outputs.
  always_ff @(posedge CLK) begin
    if (RES) begin
      sr_q  <= '0;
      cnt_q <= '0;
      ser_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      ser_q <= {sr_d[1][0], sr_d[0][0]};
    end
  end

  assign SER0 = ser_q[0];
  assign SER1 = ser_q[1];

endmodule

// File: tb/tb_nes_joypad_responder.sv
// Self-checking bench for nes_joypad_responder. A behavioural model tracks,
// per port, the snapshot taken at the last strobe and how many reads have
// completed, and derives the expected serial bit from the stream definition.
module tb_nes_joypad_responder;

  logic       CLK = 1'b0;
  logic       RES;
  logic       OUT0;
  logic       n_IN0;
  logic       n_IN1;
  logic       FS_EN;
  logic [7:0] PAD1, PAD2, PAD3, PAD4;
  logic       SER0, SER1;

  nes_joypad_responder dut (
    .CLK   (CLK),
    .RES   (RES),
    .OUT0  (OUT0),
    .n_IN0 (n_IN0),
    .n_IN1 (n_IN1),
    .FS_EN (FS_EN),
    .PAD1  (PAD1),
    .PAD2  (PAD2),
    .PAD3  (PAD3),
    .PAD4  (PAD4),
    .SER0  (SER0),
    .SER1  (SER1)
  );

  always #5 CLK = ~CLK;

  int vectors;
  int miscompares;

  // Reference model state.
  bit         m_valid;
  bit         m_fs;
  logic [7:0] m_pad [4];
  int         m_idx [2];
  bit         m_strobe_high;

  // Expected bit of read number i on port p.
  function automatic logic exp_bit(input int p, input int i);
    if (!m_valid) return (i >= 24);  // cleared register fills with ones
    if (i >= 24) return 1'b1;
    if (i < 8) return m_pad[p][i];
    if (!m_fs) return 1'b1;
    if (i < 16) return m_pad[p + 2][i - 8];
    return (i == ((p == 0) ? 19 : 18)) ? 1'b1 : 1'b0;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_both(input string tag);
    check($sformatf("%s ser0 read%0d", tag, m_idx[0]), SER0, exp_bit(0, m_idx[0]));
    check($sformatf("%s ser1 read%0d", tag, m_idx[1]), SER1, exp_bit(1, m_idx[1]));
  endtask

  task automatic take_snapshot();
    m_valid = 1'b1;
    m_fs    = FS_EN;
    m_pad[0] = PAD1;
    m_pad[1] = PAD2;
    m_pad[2] = PAD3;
    m_pad[3] = PAD4;
    m_idx[0] = 0;
    m_idx[1] = 0;
  endtask

  task automatic strobe();
    OUT0 = 1'b1;
    repeat (4) tick();
    OUT0 = 1'b0;
    repeat (4) tick();
    take_snapshot();
  endtask

  // One read pulse on the selected port(s): 3 cycles low, then settle.
  task automatic pulse(input bit p0, input bit p1);
    if (p0) n_IN0 = 1'b0;
    if (p1) n_IN1 = 1'b0;
    repeat (3) tick();
    n_IN0 = 1'b1;
    n_IN1 = 1'b1;
    repeat (4) tick();
    if (!m_strobe_high) begin
      if (p0 && m_idx[0] < 100) m_idx[0]++;
      if (p1 && m_idx[1] < 100) m_idx[1]++;
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    m_valid = 1'b0;
    m_fs = 1'b0;
    m_idx[0] = 0;
    m_idx[1] = 0;
    m_strobe_high = 1'b0;
    for (int k = 0; k < 4; k++) m_pad[k] = 8'h00;
    RES = 1'b1; OUT0 = 1'b0; n_IN0 = 1'b1; n_IN1 = 1'b1; FS_EN = 1'b0;
    PAD1 = 8'h00; PAD2 = 8'h00; PAD3 = 8'h00; PAD4 = 8'h00;
    repeat (3) tick();
    check("reset ser0", SER0, 1'b0);
    check("reset ser1", SER1, 1'b0);
    RES = 1'b0;
    tick();

    // Standard mode, A + Start on pad 1.
    PAD1 = 8'h09;
    PAD2 = 8'($urandom);
    strobe();
    check_both("std");
    for (int n = 0; n < 10; n++) begin
      pulse(1'b1, 1'b0);
      check_both("std");
    end

    // Four Score streams with signatures, both ports read together.
    FS_EN = 1'b1; PAD1 = 8'h01; PAD3 = 8'h80; PAD2 = 8'h00; PAD4 = 8'h00;
    strobe();
    check_both("fs");
    for (int n = 0; n < 26; n++) begin
      pulse(1'b1, 1'b1);
      check_both("fs");
    end

    // Strobe held high: reads are discarded, output tracks PAD1 bit 0 live.
    FS_EN = 1'b0;
    OUT0 = 1'b1;
    m_strobe_high = 1'b1;
    for (int n = 0; n < 5; n++) begin
      PAD1 = 8'($urandom);
      PAD1[0] = n[0];
      repeat (4) tick();
      check("live ser0", SER0, PAD1[0]);
      pulse(1'b1, 1'b0);
      check("held ser0", SER0, PAD1[0]);
    end
    OUT0 = 1'b0;
    repeat (4) tick();
    m_strobe_high = 1'b0;
    take_snapshot();
    check_both("after hold");
    pulse(1'b1, 1'b0);
    check_both("after hold");

    // Reset mid-stream aborts; release with enables high creates no shift.
    strobe();
    for (int n = 0; n < 3; n++) pulse(1'b1, 1'b0);
    check_both("pre reset");
    RES = 1'b1;
    tick();
    check("mid reset ser0", SER0, 1'b0);
    check("mid reset ser1", SER1, 1'b0);
    RES = 1'b0;
    m_valid = 1'b0;
    m_idx[0] = 0;
    m_idx[1] = 0;
    repeat (4) tick();
    check_both("post reset");
    PAD1 = 8'($urandom);
    strobe();
    check_both("fresh");
    for (int n = 0; n < 8; n++) begin
      pulse(1'b1, 1'b0);
      check_both("fresh");
    end

    // Saturation: long read on port 1 never wraps back to button data.
    PAD2 = 8'h5A;
    strobe();
    for (int n = 0; n < 40; n++) begin
      pulse(1'b0, 1'b1);
      check_both("sat");
    end

    // Randomized rounds; FS_EN flips mid-stream must not matter.
    for (int r = 0; r < 8; r++) begin
      FS_EN = 1'($urandom);
      PAD1 = 8'($urandom); PAD2 = 8'($urandom);
      PAD3 = 8'($urandom); PAD4 = 8'($urandom);
      strobe();
      check_both("rnd");
      for (int n = 0; n < int'($urandom_range(5, 30)); n++) begin
        int sel;
        sel = int'($urandom_range(0, 2));
        if ($urandom_range(0, 3) == 0) FS_EN = ~FS_EN;
        pulse(sel != 1, sel != 0);
        check_both("rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
